// File: rtl/timer_scheduler_pkg.sv
// timer_scheduler_pkg
//   Shared definitions for the timer scheduler: command opcodes, the
//   per-channel state encoding, the prescaler width, and a helper that
//   sizes channel-index fields (at least one bit, even for one channel).
`timescale 1ns/1ps
package timer_scheduler_pkg;

  // Command opcodes carried on cfg_op.
  typedef enum logic {
    OP_START = 1'b0,
    OP_STOP  = 1'b1
  } cfg_op_e;

  // Per-channel state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int PRESCALER_W = 32;

  // Width of a channel index; never zero so ports stay legal for one channel.
  function automatic int ch_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if
//   Groups the command and expiry-event handshakes of the timer scheduler.
//
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both 1. The source holds valid and its payload
//   stable until that edge; ready may change freely.
//
//   cfg_*  : command channel, software -> scheduler (cfg_ready from scheduler)
//   evt_*  : expiry events, scheduler -> software (evt_ready from software)
//
//   modport master : the software / bench side
//   modport slave  : the scheduler side
`timescale 1ns/1ps
interface timer_scheduler_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  import timer_scheduler_pkg::*;

  localparam int CH_W = ch_idx_w(CHANNELS);

  logic            cfg_valid;
  logic            cfg_ready;
  cfg_op_e         cfg_op;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic            cfg_periodic;

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;

  modport master (
    output cfg_valid, cfg_op, cfg_ch, cfg_period, cfg_periodic, evt_ready,
    input  cfg_ready, evt_valid, evt_ch
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_ch, cfg_period, cfg_periodic, evt_ready,
    output cfg_ready, evt_valid, evt_ch
  );

endinterface

// File: rtl/timer_scheduler_tick_prescaler.sv
// tick_prescaler
//   Divides clk into a one-cycle clock-enable strobe at f_clk/(prescaler+1).
//   The strobe is registered, so it is 0 during reset and first rises on the
//   clock edge after the counter has reached the prescaler value.
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     prescaler   : divider value; 0 gives a strobe every cycle
//     tick        : one-cycle enable strobe (not a clock)
`timescale 1ns/1ps
module tick_prescaler
  import timer_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PRESCALER_W-1:0] prescaler,
  output logic                   tick
);

  logic [PRESCALER_W-1:0] count_q, count_d;
  logic                   tick_q, tick_d;

  // Using >= rather than == means lowering prescaler below the current
  // count still produces a tick and wraps, instead of running to 2^32.
  always_comb begin
    count_d = count_q + 32'd1;
    tick_d  = 1'b0;
    if (count_q >= prescaler) begin
      count_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler
//   CHANNELS independent software timers sharing one prescaled tick. Each
//   channel counts down from its period on every tick and expires when the
//   count is already 0, so an expiry happens every period+1 ticks. Expiries
//   raise a pending bit; pending channels are presented one at a time on the
//   evt_* handshake in round-robin order, with one idle cycle between events.
//
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     prescaler    : shared tick divider (tick every prescaler+1 cycles)
//     bus          : cfg_* command and evt_* event handshakes (slave side)
//     running      : per-channel RUN state
//     overrun      : sticky, channel expired while its event was still pending
//     tick         : shared tick strobe
//     dbg_pending  : per-channel pending bits
//     dbg_rr_ptr   : channel where the next round-robin search starts
`timescale 1ns/1ps
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  localparam int CH_W    = ch_idx_w(CHANNELS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PRESCALER_W-1:0] prescaler,
  timer_scheduler_if.slave       bus,
  output logic [CHANNELS-1:0]    running,
  output logic [CHANNELS-1:0]    overrun,
  output logic                   tick,
  output logic [CHANNELS-1:0]    dbg_pending,
  output logic [CH_W-1:0]        dbg_rr_ptr
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  // Per-channel timer state.
  ch_state_e        state_q    [CHANNELS];
  ch_state_e        state_d    [CHANNELS];
  logic [CNT_W-1:0] cnt_q      [CHANNELS];
  logic [CNT_W-1:0] cnt_d      [CHANNELS];
  logic [CNT_W-1:0] period_q   [CHANNELS];
  logic [CNT_W-1:0] period_d   [CHANNELS];
  logic [CHANNELS-1:0] periodic_q, periodic_d;

  // Event bookkeeping.
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] overrun_q, overrun_d;
  logic                evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]     evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                tick_en;
  logic                cmd_fire;
  logic                evt_fire;
  logic [CHANNELS-1:0] cmd_hit;   // channel addressed by this cycle's command
  logic [CHANNELS-1:0] expire;    // channel expires on this cycle's tick
  logic [CHANNELS-1:0] stop_clr;  // STOP drops this channel's pending bit
  logic [CHANNELS-1:0] avail;     // candidates for the next presented event
  logic                search_found;
  logic [CH_W-1:0]     search_ch;

  tick_prescaler u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .prescaler (prescaler),
    .tick      (tick_en)
  );

  // Commands always complete in one cycle; ready only drops in reset.
  assign bus.cfg_ready = rst_n;
  assign cmd_fire      = bus.cfg_valid && bus.cfg_ready;
  assign evt_fire      = evt_valid_q && bus.evt_ready;

  // Channel next-state: a command to a channel overrides that channel's tick.
  always_comb begin
    cmd_hit    = '0;
    expire     = '0;
    stop_clr   = '0;
    periodic_d = periodic_q;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      period_d[c] = period_q[c];
      cmd_hit[c]  = cmd_fire && (int'(bus.cfg_ch) == c);
      if (cmd_hit[c]) begin
        if (bus.cfg_op == OP_START) begin
          state_d[c]    = RUN;
          cnt_d[c]      = bus.cfg_period;
          period_d[c]   = bus.cfg_period;
          periodic_d[c] = bus.cfg_periodic;
        end else begin
          state_d[c]  = IDLE;
          // The presented event must stay stable until it is accepted.
          stop_clr[c] = !(evt_valid_q && (int'(evt_ch_q) == c));
        end
      end else if (tick_en && (state_q[c] == RUN)) begin
        if (cnt_q[c] == '0) begin
          expire[c] = 1'b1;
          if (periodic_q[c]) begin
            cnt_d[c] = period_q[c];
          end else begin
            state_d[c] = IDLE;
          end
        end else begin
          cnt_d[c] = cnt_q[c] - CNT_ONE;
        end
      end
    end
  end

  // Pending / overrun / event presentation.
  always_comb begin
    int idx;
    idx          = 0;
    pending_d    = pending_q;
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    rr_ptr_d     = rr_ptr_q;
    search_found = 1'b0;
    search_ch    = '0;

    // Handshake clear first so a same-cycle expiry of that channel re-sets it.
    if (evt_fire) begin
      pending_d[evt_ch_q] = 1'b0;
    end
    pending_d = (pending_d | expire) & ~stop_clr;
    overrun_d = (overrun_q | (expire & pending_q)) & ~cmd_hit;

    // Round-robin search from rr_ptr; a channel being stopped this cycle is
    // not offered, so no event is presented for an already-cleared bit.
    avail = pending_q & ~stop_clr;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!search_found && avail[idx]) begin
        search_found = 1'b1;
        search_ch    = CH_W'(idx);
      end
    end

    if (evt_valid_q) begin
      if (bus.evt_ready) begin
        evt_valid_d = 1'b0;
        rr_ptr_d    = (evt_ch_q == CH_LAST) ? '0 : evt_ch_q + CH_ONE;
      end
    end else if (search_found) begin
      evt_valid_d = 1'b1;
      evt_ch_d    = search_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= IDLE;
        cnt_q[c]    <= '0;
        period_q[c] <= '0;
      end
      periodic_q  <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= state_d[c];
        cnt_q[c]    <= cnt_d[c];
        period_q[c] <= period_d[c];
      end
      periodic_q  <= periodic_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      running[c] = (state_q[c] == RUN);
    end
  end

  assign overrun       = overrun_q;
  assign tick          = tick_en;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_ch    = evt_ch_q;
  assign dbg_pending   = pending_q;
  assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler
//   Self-checking bench for timer_scheduler: a table of single-channel
//   latency vectors, hand-written multi-cycle sequences, and a randomized
//   phase compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_timer_scheduler;
  import timer_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  prescaler = '0;
  logic [N-1:0] running, overrun, dbg_pending;
  logic         tick;
  logic [1:0]   dbg_rr_ptr;

  timer_scheduler_if #(.CHANNELS(N), .CNT_W(CW)) bus ();

  timer_scheduler #(.CHANNELS(N), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prescaler   (prescaler),
    .bus         (bus),
    .running     (running),
    .overrun     (overrun),
    .tick        (tick),
    .dbg_pending (dbg_pending),
    .dbg_rr_ptr  (dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_valid    = 1'b0;
    bus.cfg_op       = OP_START;
    bus.cfg_ch       = '0;
    bus.cfg_period   = '0;
    bus.cfg_periodic = 1'b0;
  endtask

  // Ends at the negedge just after release; the next posedge is edge 1.
  task automatic do_reset(input int pre);
    rst_n = 1'b0;
    idle_inputs();
    bus.evt_ready = 1'b0;
    prescaler = 32'(pre);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; the command transfers on the next posedge and the
  // task returns at the negedge after it.
  task automatic send_cmd(input cfg_op_e op, input int ch, input int period, input bit periodic);
    bus.cfg_valid    = 1'b1;
    bus.cfg_op       = op;
    bus.cfg_ch       = 2'(ch);
    bus.cfg_period   = 16'(period);
    bus.cfg_periodic = periodic;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    while (!bus.evt_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int pre;
    int ch;
    int period;
    bit periodic;
    int exp_lat;   // edges from the START edge until evt_valid is seen
  } vec_t;

  vec_t vecs[6];

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Each channel holds "ticks left before it fires" plus its reload rule; the
  // tick schedule is derived arithmetically from the edge index.
  int   pre_cur;
  bit   m_run[N];
  int   m_left[N];
  int   m_reload[N];
  bit   m_auto[N];
  bit   m_pend[N];
  bit   m_ovr[N];
  bit   m_valid;
  int   m_ch;
  int   m_rr;

  task automatic model_reset(input int pre);
    pre_cur = pre;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_left[c] = 0; m_reload[c] = 0; m_auto[c] = 0;
      m_pend[c] = 0; m_ovr[c] = 0;
    end
    m_valid = 0; m_ch = 0; m_rr = 0;
  endtask

  function automatic bit tick_after_edge(input int e);
    return (e >= 1) && ((e % (pre_cur + 1)) == 0);
  endfunction

  // Advance the model across edge e using the inputs currently driven.
  task automatic model_step(input int e);
    bit t, hs, found;
    bit np[N];
    bit no[N];
    bit cand[N];
    int c;
    t  = tick_after_edge(e - 1);
    hs = m_valid && bus.evt_ready;
    for (int k = 0; k < N; k++) begin
      np[k] = m_pend[k]; no[k] = m_ovr[k]; cand[k] = m_pend[k];
    end
    if (hs) np[m_ch] = 0;
    for (int k = 0; k < N; k++) begin
      if (bus.cfg_valid && int'(bus.cfg_ch) == k) begin
        no[k] = 0;
        if (bus.cfg_op == OP_START) begin
          m_run[k] = 1; m_left[k] = int'(bus.cfg_period);
          m_reload[k] = int'(bus.cfg_period); m_auto[k] = bus.cfg_periodic;
        end else begin
          m_run[k] = 0;
          if (!(m_valid && m_ch == k)) begin
            np[k] = 0; cand[k] = 0;
          end
        end
      end else if (t && m_run[k]) begin
        if (m_left[k] == 0) begin
          np[k] = 1;
          if (m_pend[k]) no[k] = 1;
          if (m_auto[k]) m_left[k] = m_reload[k];
          else m_run[k] = 0;
        end else begin
          m_left[k] = m_left[k] - 1;
        end
      end
    end
    if (m_valid) begin
      if (hs) begin
        m_valid = 0;
        m_rr = (m_ch + 1) % N;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!found && cand[c]) begin
          found = 1; m_valid = 1; m_ch = c;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      m_pend[k] = np[k]; m_ovr[k] = no[k];
    end
  endtask

  task automatic model_compare(input int e);
    logic [N-1:0] er, eo;
    for (int k = 0; k < N; k++) begin
      er[k] = m_run[k]; eo[k] = m_ovr[k];
    end
    check("rand_evt_valid", 32'(bus.evt_valid), 32'(m_valid));
    if (m_valid) check("rand_evt_ch", 32'(bus.evt_ch), 32'(m_ch));
    check("rand_running", 32'(running), 32'(er));
    check("rand_overrun", 32'(overrun), 32'(eo));
    check("rand_tick", 32'(tick), 32'(tick_after_edge(e)));
  endtask

  // ---------------- test ----------------
  initial begin
    int n, p, extra, hs_prev;
    logic [1:0] got;

    vecs[0] = '{pre: 0, ch: 0, period: 3, periodic: 1, exp_lat: 5};
    vecs[1] = '{pre: 9, ch: 1, period: 0, periodic: 0, exp_lat: 11};
    vecs[2] = '{pre: 2, ch: 2, period: 4, periodic: 1, exp_lat: 16};
    vecs[3] = '{pre: 1, ch: 3, period: 0, periodic: 0, exp_lat: 3};
    vecs[4] = '{pre: 0, ch: 1, period: 0, periodic: 0, exp_lat: 2};
    vecs[5] = '{pre: 3, ch: 0, period: 1, periodic: 1, exp_lat: 9};

    idle_inputs();
    bus.evt_ready = 1'b0;

    // Reset values.
    do_reset(0);
    check("reset_evt_valid", 32'(bus.evt_valid), 0);
    check("reset_running", 32'(running), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_pending", 32'(dbg_pending), 0);
    check("reset_cfg_ready", 32'(bus.cfg_ready), 1);

    // Table: single channel, latency, channel id, interval / one-shot end.
    foreach (vecs[i]) begin
      do_reset(vecs[i].pre);
      bus.evt_ready = 1'b1;
      send_cmd(OP_START, vecs[i].ch, vecs[i].period, vecs[i].periodic);
      wait_valid(400, n);
      check("vec_latency", 32'(n), 32'(vecs[i].exp_lat));
      check("vec_evt_ch", 32'(bus.evt_ch), 32'(vecs[i].ch));
      check("vec_running", 32'(running[vecs[i].ch]), 32'(vecs[i].periodic));
      p = (vecs[i].period + 1) * (vecs[i].pre + 1);
      @(negedge clk);
      check("vec_bubble", 32'(bus.evt_valid), 0);
      if (vecs[i].periodic) begin
        wait_valid(400, n);
        check("vec_interval", 32'(n + 1), 32'(p));
        check("vec_evt_ch2", 32'(bus.evt_ch), 32'(vecs[i].ch));
        check("vec_overrun", 32'(overrun), 0);
      end else begin
        extra = 0;
        repeat (3 * p + 10) begin
          @(negedge clk);
          if (bus.evt_valid) extra++;
        end
        check("vec_oneshot_extra", 32'(extra), 0);
      end
    end

    // Four channels expiring on one tick: round-robin order, one bubble.
    do_reset(7);
    bus.evt_ready = 1'b1;
    for (int c = 0; c < N; c++) send_cmd(OP_START, c, 1, 1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) exp_q.push_back(2'(c));
    hs_prev = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      if (hs_prev) check("rr_bubble", 32'(bus.evt_valid), 0);
      hs_prev = 0;
      if (bus.evt_valid && bus.evt_ready) begin
        got = exp_q.pop_front();
        check("rr_order", 32'(bus.evt_ch), 32'(got));
        hs_prev = 1;
      end
      @(negedge clk);
      n++;
    end
    check("rr_all_served", 32'(exp_q.size()), 0);
    exp_q.delete();

    // Held event and overrun, cleared by a restart.
    do_reset(0);
    send_cmd(OP_START, 2, 2, 1);
    wait_valid(50, n);
    check("hold_first_ch", 32'(bus.evt_ch), 2);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (!bus.evt_valid || bus.evt_ch != 2'd2) extra++;
    end
    check("hold_stable", 32'(extra), 0);
    check("hold_overrun", 32'(overrun[2]), 1);
    send_cmd(OP_START, 2, 2, 1);
    check("restart_clears_overrun", 32'(overrun[2]), 0);
    check("restart_keeps_event", 32'(bus.evt_valid), 1);

    // STOP of the presented channel: event stays until accepted, then silence.
    do_reset(0);
    send_cmd(OP_START, 3, 2, 1);
    wait_valid(50, n);
    check("stop_pre_ch", 32'(bus.evt_ch), 3);
    send_cmd(OP_STOP, 3, 0, 0);
    check("stop_held_valid", 32'(bus.evt_valid), 1);
    check("stop_held_ch", 32'(bus.evt_ch), 3);
    check("stop_running", 32'(running[3]), 0);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    check("stop_accepted", 32'(bus.evt_valid), 0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.evt_valid) extra++;
    end
    check("stop_no_more", 32'(extra), 0);

    // Reset mid-operation with an event presented and two pending.
    do_reset(0);
    send_cmd(OP_START, 0, 0, 1);
    send_cmd(OP_START, 1, 0, 1);
    repeat (3) @(negedge clk);
    check("rst_pre_valid", 32'(bus.evt_valid), 1);
    check("rst_pre_pending", 32'(dbg_pending[1:0]), 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("rst_evt_valid", 32'(bus.evt_valid), 0);
    check("rst_evt_ch", 32'(bus.evt_ch), 0);
    check("rst_running", 32'(running), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 0);
    check("rst_pending", 32'(dbg_pending), 0);
    check("rst_rr_ptr", 32'(dbg_rr_ptr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.evt_ready = 1'b1;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.evt_valid || running != '0) extra++;
    end
    check("rst_quiet_after", 32'(extra), 0);

    // Randomized phase against the model.
    for (int pass = 0; pass < 3; pass++) begin
      int pre_r;
      pre_r = $urandom_range(0, 3);
      do_reset(pre_r);
      model_reset(pre_r);
      for (int e = 0; e < 1500; e++) begin
        model_compare(e);
        bus.cfg_valid    = ($urandom_range(0, 3) == 0);
        bus.cfg_op       = ($urandom_range(0, 9) < 6) ? OP_START : OP_STOP;
        bus.cfg_ch       = 2'($urandom_range(0, N - 1));
        bus.cfg_period   = 16'($urandom_range(0, 5));
        bus.cfg_periodic = 1'($urandom_range(0, 1));
        bus.evt_ready    = 1'($urandom_range(0, 1));
        model_step(e + 1);
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
